vrf_wb_arbiter: RTL



---
 rtl/vrf_wb_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vrf_wb_arbiter.sv
// Write-back arbiter for the vector register file's single write port.
// MANDA results are split into two consecutive 64-bit writes (low, then high).
module vrf_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_req,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_gnt,
    input  logic                lsu_req,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_data,
    output logic                lsu_gnt,
    input  logic                manda_req,
    input  logic [ADDR_W-1:0]   manda_addr,
    input  logic [2*DATA_W-1:0] manda_data,
    output logic                manda_gnt,
    output logic                W_En,
    output logic [ADDR_W-1:0]   W_Addr,
    output logic [DATA_W-1:0]   WR,
    output logic                MANDA_En,
    output logic [2*DATA_W-1:0] M_ALU_Out,
    output logic                busy
);

    typedef enum logic {IDLE, M_HI} state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;          // 0: ALU favoured, 1: LSU favoured
    logic [ADDR_W-1:0]   hi_addr_q, hi_addr_d;
    logic [DATA_W-1:0]   hi_data_q, hi_data_d;
    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [DATA_W-1:0]   wr_q, wr_d;
    logic                manda_en_q, manda_en_d;
    logic [2*DATA_W-1:0] m_out_q, m_out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (manda_gnt) state_d = M_HI;
                if (alu_gnt)   ptr_d = 1'b1;
                if (lsu_gnt)   ptr_d = 1'b0;
            end
            M_HI:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants are gated by rst so every gnt reads 0 while reset is held.
    always_comb begin
        alu_gnt   = 1'b0;
        lsu_gnt   = 1'b0;
        manda_gnt = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (manda_req)                          manda_gnt = 1'b1;
            else if (alu_req && (!lsu_req || !ptr_q)) alu_gnt = 1'b1;
            else if (lsu_req)                       lsu_gnt   = 1'b1;
        end
    end

    always_comb begin
        w_en_d     = 1'b0;
        w_addr_d   = w_addr_q;
        wr_d       = wr_q;
        manda_en_d = 1'b0;
        m_out_d    = m_out_q;
        hi_addr_d  = hi_addr_q;
        hi_data_d  = hi_data_q;
        if (state_q == M_HI) begin
            w_en_d   = 1'b1;
            w_addr_d = hi_addr_q;
            wr_d     = hi_data_q;
        end else if (manda_gnt) begin
            w_en_d     = 1'b1;
            w_addr_d   = manda_addr;
            wr_d       = manda_data[DATA_W-1:0];
            manda_en_d = 1'b1;
            m_out_d    = manda_data;
            hi_addr_d  = manda_addr + ADDR_W'(1);
            hi_data_d  = manda_data[2*DATA_W-1:DATA_W];
        end else if (alu_gnt) begin
            w_en_d   = 1'b1;
            w_addr_d = alu_addr;
            wr_d     = alu_data;
        end else if (lsu_gnt) begin
            w_en_d   = 1'b1;
            w_addr_d = lsu_addr;
            wr_d     = lsu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            wr_q       <= '0;
            manda_en_q <= 1'b0;
            m_out_q    <= '0;
            hi_addr_q  <= '0;
            hi_data_q  <= '0;
        end else begin
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            wr_q       <= wr_d;
            manda_en_q <= manda_en_d;
            m_out_q    <= m_out_d;
            hi_addr_q  <= hi_addr_d;
            hi_data_q  <= hi_data_d;
        end
    end

    assign W_En      = w_en_q;
    assign W_Addr    = w_addr_q;
    assign WR        = wr_q;
    assign MANDA_En  = manda_en_q;
    assign M_ALU_Out = m_out_q;
    assign busy      = (state_q == M_HI);

endmodule
